processor: RTL and testbench

- Multi-cycle, non-pipelined 32-bit CPU executing a Nios II-style subset over a single unified instruction/data memory port.
- Sits between system memory (or bus bridge) and nothing else; the only agent driving memory address/data/strobes.
- FSM sequences fetch, decode, execute, memory and writeback; iRDY stretches any memory access.

---
 rtl/processor_pkg.sv | 50 +++++
 rtl/processor_regfile.sv | 38 +++
 rtl/processor.sv | 170 +++++++++++++++++
 tb/tb_processor.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// Shared definitions for the multi-cycle Nios II-style processor:
// opcode/OPX constants, instruction field positions, FSM state encoding
// and the immediate sign-extension helper.
package processor_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned IMM_W  = 16;

  // Instruction field positions (I-type and R-type share A/B)
  localparam int unsigned A_MSB   = 31;
  localparam int unsigned A_LSB   = 27;
  localparam int unsigned B_MSB   = 26;
  localparam int unsigned B_LSB   = 22;
  localparam int unsigned C_MSB   = 21;
  localparam int unsigned C_LSB   = 17;
  localparam int unsigned IMM_MSB = 21;
  localparam int unsigned IMM_LSB = 6;
  localparam int unsigned OPX_MSB = 16;
  localparam int unsigned OPX_LSB = 11;
  localparam int unsigned OP_MSB  = 5;
  localparam int unsigned OP_LSB  = 0;

  // Primary opcodes
  localparam logic [OP_W-1:0] OP_LDW  = 6'h17;
  localparam logic [OP_W-1:0] OP_STW  = 6'h15;
  localparam logic [OP_W-1:0] OP_ADDI = 6'h04;
  localparam logic [OP_W-1:0] OP_BR   = 6'h06;
  localparam logic [OP_W-1:0] OP_BLT  = 6'h16;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'h26;
  localparam logic [OP_W-1:0] OP_R    = 6'h3A;

  // R-type extended opcodes
  localparam logic [OP_W-1:0] OPX_ADD = 6'h31;
  localparam logic [OP_W-1:0] OPX_SUB = 6'h39;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4
  } state_t;

  function automatic logic [WORD_W-1:0] sext16(input logic [IMM_W-1:0] imm);
    return {{(WORD_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/processor_regfile.sv
// 32x32 register file: r0 reads as zero and ignores writes.
// Ports: clk, rst (sync active-high, clears all registers),
//        raddr_a/raddr_b -> rdata_a_c/rdata_b_c (combinational reads),
//        we/waddr/wdata (synchronous write).
module processor_regfile
  import processor_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [WORD_W-1:0] rdata_a_c,
  output logic [WORD_W-1:0] rdata_b_c,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [WORD_W-1:0] wdata
);

  localparam int unsigned NREGS = 32;

  logic [WORD_W-1:0] regs [NREGS];

  // Write port; entry 0 is never written so it stays zero after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports with r0 forced to zero
  assign rdata_a_c = (raddr_a == '0) ? '0 : regs[raddr_a];
  assign rdata_b_c = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/processor.sv
// Multi-cycle, non-pipelined 32-bit CPU (Nios II-style subset) on a single
// unified memory port. FSM: FETCH -> DECODE -> EXECUTE -> [MEM] -> [WB].
// Ports: iClk clock; nRst sync active-high reset; iRDY memory ready;
//        oMemAddr/oMemData/oMemRead/oMemWrite memory request (registered);
//        iMemData read data, valid when iRDY is high.
module processor
  import processor_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned       DATA_W   = WORD_W
) (
  input  logic              iClk,
  input  logic              nRst,
  input  logic              iRDY,
  output logic [DATA_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemData,
  input  logic [DATA_W-1:0] iMemData,
  output logic              oMemRead,
  output logic              oMemWrite
);

  state_t            state, state_d;
  logic [DATA_W-1:0] pc, pc_d;
  logic [DATA_W-1:0] ir, ir_d;
  logic [DATA_W-1:0] ra_q, ra_d;
  logic [DATA_W-1:0] rb_q, rb_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] alu_q, alu_d;     // ALU result, effective address or load data
  logic [DATA_W-1:0] mem_addr_d, mem_data_d;
  logic              mem_read_d, mem_write_d;

  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_rdata_a, rf_rdata_b;

  logic [OP_W-1:0]   op, opx;
  logic [REG_AW-1:0] fld_a, fld_b, fld_c;
  logic [IMM_W-1:0]  fld_imm;

  assign op      = ir[OP_MSB:OP_LSB];
  assign opx     = ir[OPX_MSB:OPX_LSB];
  assign fld_a   = ir[A_MSB:A_LSB];
  assign fld_b   = ir[B_MSB:B_LSB];
  assign fld_c   = ir[C_MSB:C_LSB];
  assign fld_imm = ir[IMM_MSB:IMM_LSB];

  processor_regfile u_regfile (
    .clk       (iClk),
    .rst       (nRst),
    .raddr_a   (fld_a),
    .raddr_b   (fld_b),
    .rdata_a_c (rf_rdata_a),
    .rdata_b_c (rf_rdata_b),
    .we        (rf_we),
    .waddr     (rf_waddr),
    .wdata     (alu_q)
  );

  // State and datapath registers; bus outputs are registered from next state
  always_ff @(posedge iClk) begin
    if (nRst) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      oMemAddr  <= RESET_PC;
      oMemData  <= '0;
      oMemRead  <= 1'b1;
      oMemWrite <= 1'b0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      ir        <= ir_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      imm_q     <= imm_d;
      alu_q     <= alu_d;
      oMemAddr  <= mem_addr_d;
      oMemData  <= mem_data_d;
      oMemRead  <= mem_read_d;
      oMemWrite <= mem_write_d;
    end
  end

  // Next-state, datapath and next-cycle bus request
  always_comb begin
    state_d  = state;
    pc_d     = pc;
    ir_d     = ir;
    ra_d     = ra_q;
    rb_d     = rb_q;
    imm_d    = imm_q;
    alu_d    = alu_q;
    rf_we    = 1'b0;
    rf_waddr = fld_b;

    case (state)
      S_FETCH: begin
        if (iRDY) begin
          ir_d    = iMemData;
          pc_d    = pc + DATA_W'(4);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ra_d    = rf_rdata_a;
        rb_d    = rf_rdata_b;
        imm_d   = sext16(fld_imm);
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        // pc already points at the next sequential instruction here
        state_d = S_FETCH;
        case (op)
          OP_LDW, OP_STW: begin
            alu_d   = ra_q + imm_q;
            state_d = S_MEM;
          end
          OP_ADDI: begin
            alu_d   = ra_q + imm_q;
            state_d = S_WB;
          end
          OP_BR: pc_d = pc + imm_q;
          OP_BLT: begin
            if ($signed(ra_q) < $signed(rb_q)) pc_d = pc + imm_q;
          end
          OP_BEQ: begin
            if (ra_q == rb_q) pc_d = pc + imm_q;
          end
          OP_R: begin
            if (opx == OPX_ADD) begin
              alu_d   = ra_q + rb_q;
              state_d = S_WB;
            end else if (opx == OPX_SUB) begin
              alu_d   = ra_q - rb_q;
              state_d = S_WB;
            end
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (iRDY) begin
          if (op == OP_LDW) begin
            alu_d   = iMemData;
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_waddr = (op == OP_R) ? fld_c : fld_b;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Bus request for the state being entered
    mem_read_d  = (state_d == S_FETCH) || ((state_d == S_MEM) && (op == OP_LDW));
    mem_write_d = (state_d == S_MEM) && (op == OP_STW);
    mem_addr_d  = (state_d == S_MEM) ? alu_d : pc_d;
    mem_data_d  = mem_write_d ? rb_q : '0;
  end

endmodule

// File: tb/tb_processor.sv
// Directed self-checking bench for processor: runs a small program from a
// behavioural memory and checks bus activity, fetch addresses and registers.
module tb_processor;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_read;
  logic        mem_write;

  logic [31:0] mem [0:2047];
  int          checks   = 0;
  int          failures = 0;
  int          store_count = 0;

  processor dut (
    .iClk      (clk),
    .nRst      (rst),
    .iRDY      (rdy),
    .oMemAddr  (mem_addr),
    .oMemData  (mem_wdata),
    .iMemData  (mem_rdata),
    .oMemRead  (mem_read),
    .oMemWrite (mem_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[12:2]];

  // Completed stores seen on the bus
  always @(posedge clk) begin
    if (!rst && mem_write && rdy) store_count <= store_count + 1;
  end

  function automatic logic [31:0] enc_i(input int a, input int b,
                                        input logic [15:0] imm, input logic [5:0] op);
    return {5'(a), 5'(b), imm, op};
  endfunction

  function automatic logic [31:0] enc_r(input int a, input int b, input int c,
                                        input logic [5:0] opx);
    return {5'(a), 5'(b), 5'(c), opx, 5'b0, 6'h3A};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) for a write strobe, then check the store request
  task automatic wait_store(input string tag, input logic [31:0] addr, input logic [31:0] data);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (mem_write === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_seen"}, 32'(found), 32'd1);
    check({tag, "_addr"}, mem_addr, addr);
    check({tag, "_data"}, mem_wdata, data);
    check({tag, "_rd"},   32'(mem_read), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    mem[32'h00 >> 2] = enc_i(0, 1, 16'h1000, 6'h17);  // ldw r1,0x1000(r0)
    mem[32'h04 >> 2] = enc_i(0, 2, 16'h1004, 6'h17);  // ldw r2,0x1004(r0)
    mem[32'h08 >> 2] = enc_r(1, 2, 1, 6'h39);         // sub r1,r1,r2
    mem[32'h0C >> 2] = enc_i(0, 1, 16'h1000, 6'h15);  // stw r1,0x1000(r0)
    mem[32'h10 >> 2] = enc_i(0, 1, 16'hFFF0, 6'h16);  // blt r0,r1,-16
    mem[32'h14 >> 2] = enc_i(1, 1, 16'hFFFF, 6'h04);  // addi r1,r1,-1
    mem[32'h18 >> 2] = enc_i(2, 0, 16'h0005, 6'h04);  // addi r0,r2,5
    mem[32'h1C >> 2] = enc_i(0, 1, 16'h1008, 6'h15);  // stw r1,0x1008(r0)
    mem[32'h20 >> 2] = enc_i(0, 0, 16'h0008, 6'h26);  // beq r0,r0,+8
    mem[32'h24 >> 2] = enc_i(0, 2, 16'h100C, 6'h15);  // skipped
    mem[32'h28 >> 2] = enc_i(0, 2, 16'h100C, 6'h15);  // skipped
    mem[32'h2C >> 2] = enc_i(1, 0, 16'h0008, 6'h16);  // blt r1,r0,+8
    mem[32'h30 >> 2] = enc_i(0, 2, 16'h100C, 6'h15);  // skipped
    mem[32'h34 >> 2] = enc_i(0, 2, 16'h100C, 6'h15);  // skipped
    mem[32'h38 >> 2] = enc_r(1, 1, 3, 6'h31);         // add r3,r1,r1
    mem[32'h3C >> 2] = enc_i(0, 3, 16'h1010, 6'h15);  // stw r3,0x1010(r0)
    mem[32'h40 >> 2] = enc_i(0, 0, 16'h0000, 6'h3F);  // unknown op: nop
    mem[32'h44 >> 2] = enc_r(1, 1, 5, 6'h00);         // unknown opx: nop
    mem[32'h48 >> 2] = enc_i(0, 4, 16'h1014, 6'h17);  // ldw r4,0x1014(r0)
    mem[32'h4C >> 2] = enc_i(0, 4, 16'h1018, 6'h15);  // stw r4,0x1018(r0)
    mem[32'h50 >> 2] = enc_i(0, 0, 16'hFFFC, 6'h06);  // br -4 (self)
    mem[32'h1000 >> 2] = 32'd2;
    mem[32'h1004 >> 2] = 32'd1;
    mem[32'h1014 >> 2] = 32'hCAFE_F00D;

    // Reset
    rst = 1'b1;
    rdy = 1'b1;
    step(1);
    check("rst_addr",  mem_addr, 32'h0);
    check("rst_read",  32'(mem_read), 32'd1);
    check("rst_write", 32'(mem_write), 32'd0);
    check("rst_data",  mem_wdata, 32'h0);
    rst = 1'b0;

    // Two loads, 5 cycles each
    step(10);
    check("ldw_r1", dut.u_regfile.regs[1], 32'd2);
    check("ldw_r2", dut.u_regfile.regs[2], 32'd1);
    check("fetch_08", mem_addr, 32'h08);

    // Loop: first pass stores 1 and branches back to 0x4
    wait_store("st1", 32'h1000, 32'd1);
    step(1);
    check("fetch_10a", mem_addr, 32'h10);
    step(3);
    check("blt_taken", mem_addr, 32'h04);

    // Second pass stores 0 and falls through
    wait_store("st2", 32'h1000, 32'd0);
    step(1);
    check("fetch_10b", mem_addr, 32'h10);
    step(3);
    check("blt_fall", mem_addr, 32'h14);
    check("fall_read", 32'(mem_read), 32'd1);

    // addi wraps to all-ones; addi to r0 discarded
    wait_store("st3", 32'h1008, 32'hFFFF_FFFF);
    check("r1_neg1", dut.u_regfile.regs[1], 32'hFFFF_FFFF);
    check("r0_zero", dut.u_regfile.regs[0], 32'h0);

    // beq taken, signed blt taken
    step(1);
    check("fetch_20", mem_addr, 32'h20);
    step(3);
    check("beq_taken", mem_addr, 32'h2C);
    step(3);
    check("blt_signed", mem_addr, 32'h38);

    // add result stored
    wait_store("st4", 32'h1010, 32'hFFFF_FFFE);
    check("store_count", 32'(store_count), 32'd3);

    // Two NOPs, 3 cycles each
    step(1);
    check("fetch_40", mem_addr, 32'h40);
    step(3);
    check("fetch_44", mem_addr, 32'h44);
    step(3);
    check("fetch_48", mem_addr, 32'h48);

    // Fetch stall
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("fstall_addr", mem_addr, 32'h48);
      check("fstall_read", 32'(mem_read), 32'd1);
    end
    rdy = 1'b1;
    step(3);
    check("ldw_mem_addr",  mem_addr, 32'h1014);
    check("ldw_mem_read",  32'(mem_read), 32'd1);
    check("ldw_mem_write", 32'(mem_write), 32'd0);

    // Load stall
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("mstall_addr", mem_addr, 32'h1014);
      check("mstall_read", 32'(mem_read), 32'd1);
    end
    rdy = 1'b1;
    step(2);
    check("ldw_r4", dut.u_regfile.regs[4], 32'hCAFE_F00D);
    check("fetch_4c", mem_addr, 32'h4C);

    // Reset during stw MEM
    step(3);
    check("stw_write", 32'(mem_write), 32'd1);
    check("stw_addr",  mem_addr, 32'h1018);
    check("stw_data",  mem_wdata, 32'hCAFE_F00D);
    rdy = 1'b0;
    rst = 1'b1;
    step(1);
    check("mrst_write", 32'(mem_write), 32'd0);
    check("mrst_read",  32'(mem_read), 32'd1);
    check("mrst_addr",  mem_addr, 32'h0);
    check("mrst_r4",    dut.u_regfile.regs[4], 32'h0);
    rst = 1'b0;
    rdy = 1'b1;
    step(1);
    check("restart_decode", 32'(mem_read), 32'd0);
    check("store_total", 32'(store_count), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
